// File: rtl/t_ff_bank.sv
`default_nettype none
// t_ff_bank: multi-channel toggle flip-flop bank with set/clear/load modes,
// saturating per-channel toggle counters and a registered any-toggle pulse. Rev 1.0
module t_ff_bank #(
  parameter int                 WIDTH     = 4,
  parameter int                 CNT_W     = 8,
  parameter int                 EDGE_MODE = 0,
  parameter logic [WIDTH-1:0]   INIT      = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        enable,
  input  logic [WIDTH-1:0]        d,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        load_val,
  input  logic                    count_clr,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH*CNT_W-1:0]  toggle_count,
  output logic [WIDTH-1:0]        sat,
  output logic                    any_toggle
);

  localparam logic [1:0]       MODE_TOGGLE = 2'b00;
  localparam logic [1:0]       MODE_SET    = 2'b01;
  localparam logic [1:0]       MODE_CLEAR  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH-1:0]       d_prev_q, d_prev_d;
  logic [WIDTH-1:0]       sat_q, sat_d;
  logic [WIDTH*CNT_W-1:0] cnt_q, cnt_d;
  logic                   any_q, any_d;
  logic [WIDTH-1:0]       trig;
  logic [WIDTH-1:0]       tog_ev;

  always_comb begin
    trig     = (EDGE_MODE != 0) ? (d & ~d_prev_q) : d;
    tog_ev   = (mode == MODE_TOGGLE) ? (enable & trig) : {WIDTH{1'b0}};
    any_d    = |tog_ev;
    d_prev_d = d;
  end

  // Only toggle events feed the counters; set/clear/load change q silently.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (enable[i]) begin
        case (mode)
          MODE_TOGGLE: if (trig[i]) q_d[i] = ~q_q[i];
          MODE_SET:    if (d[i])    q_d[i] = 1'b1;
          MODE_CLEAR:  if (d[i])    q_d[i] = 1'b0;
          default:                  q_d[i] = load_val[i];
        endcase
      end
      if (count_clr) begin
        cnt_d[i*CNT_W +: CNT_W] = {CNT_W{1'b0}};
        sat_d[i]                = 1'b0;
      end else if (tog_ev[i]) begin
        if (cnt_q[i*CNT_W +: CNT_W] == CNT_MAX) begin
          sat_d[i] = 1'b1;
        end else begin
          cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= INIT;
      d_prev_q <= {WIDTH{1'b0}};
      sat_q    <= {WIDTH{1'b0}};
      cnt_q    <= {(WIDTH*CNT_W){1'b0}};
      any_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      d_prev_q <= d_prev_d;
      sat_q    <= sat_d;
      cnt_q    <= cnt_d;
      any_q    <= any_d;
    end
  end

  assign q            = q_q;
  assign toggle_count = cnt_q;
  assign sat          = sat_q;
  assign any_toggle   = any_q;

endmodule
`default_nettype wire

// File: tb/tb_t_ff_bank.sv
`default_nettype none
// tb_t_ff_bank: drives a level-mode (CNT_W=3) and an edge-mode (CNT_W=8) bank
// from shared inputs and compares both against a per-channel reference model.
module tb_t_ff_bank;

  localparam logic [3:0] INIT_V = 4'b1010;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  enable, d, load_val;
  logic [1:0]  mode;
  logic        count_clr;

  logic [3:0]  q0, sat0, q1, sat1;
  logic [11:0] tc0;
  logic [31:0] tc1;
  logic        any0, any1;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state, index 0 = level/CNT_W=3, 1 = edge/CNT_W=8
  logic [3:0] m_q   [2];
  logic [3:0] m_sat [2];
  logic [3:0] m_dp  [2];
  logic       m_any [2];
  int         m_cnt [2][4];
  int         c_max  [2] = '{7, 255};
  int         c_edge [2] = '{0, 1};

  t_ff_bank #(.WIDTH(4), .CNT_W(3), .EDGE_MODE(0), .INIT(INIT_V)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .d(d), .mode(mode),
    .load_val(load_val), .count_clr(count_clr),
    .q(q0), .toggle_count(tc0), .sat(sat0), .any_toggle(any0));

  t_ff_bank #(.WIDTH(4), .CNT_W(8), .EDGE_MODE(1), .INIT(INIT_V)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .d(d), .mode(mode),
    .load_val(load_val), .count_clr(count_clr),
    .q(q1), .toggle_count(tc1), .sat(sat1), .any_toggle(any1));

  always #5 clk = ~clk;

  function automatic logic [3:0] dut_q(int k);
    return (k == 0) ? q0 : q1;
  endfunction

  function automatic logic [3:0] dut_sat(int k);
    return (k == 0) ? sat0 : sat1;
  endfunction

  function automatic logic dut_any(int k);
    return (k == 0) ? any0 : any1;
  endfunction

  function automatic int dut_cnt(int k, int i);
    return (k == 0) ? int'((tc0 >> (i*3)) & 12'h7) : int'((tc1 >> (i*8)) & 32'hFF);
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_q[k] = INIT_V; m_sat[k] = '0; m_dp[k] = '0; m_any[k] = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      end else begin
        m_any[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          bit t;
          t = (c_edge[k] != 0) ? (d[i] && !m_dp[k][i]) : d[i];
          if (enable[i]) begin
            if (mode == 2'd0 && t) begin
              m_q[k][i] = ~m_q[k][i];
              m_any[k]  = 1'b1;
              if (!count_clr) begin
                if (m_cnt[k][i] == c_max[k]) m_sat[k][i] = 1'b1;
                else m_cnt[k][i] = m_cnt[k][i] + 1;
              end
            end else if (mode == 2'd1 && d[i]) m_q[k][i] = 1'b1;
            else if (mode == 2'd2 && d[i]) m_q[k][i] = 1'b0;
            else if (mode == 2'd3) m_q[k][i] = load_val[i];
          end
        end
        if (count_clr) begin
          m_sat[k] = '0;
          for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
        end
        m_dp[k] = d;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 4'($urandom); d = 4'($urandom); mode = 2'($urandom);
    load_val = 4'($urandom); count_clr = 1'($urandom);
    step();
    reset = 1'b0; count_clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (dut_q(k) !== INIT_V) $display("FAIL reset_q dut%0d: got %b expected %b", k, dut_q(k), INIT_V);
      else n_pass++;
      n_total++;
      if (dut_sat(k) !== 4'b0000 || dut_any(k) !== 1'b0)
        $display("FAIL reset_sat_any dut%0d: got sat=%b any=%b expected 0000/0", k, dut_sat(k), dut_any(k));
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (dut_cnt(k, i) !== 0) $display("FAIL reset_cnt dut%0d ch%0d: got %0d expected 0", k, i, dut_cnt(k, i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_level_toggle();
    do_reset();
    mode = 2'b00; enable = 4'b0001; d = 4'b0001;
    for (int n = 1; n <= 5; n++) begin
      step();
      n_total++;
      if (any0 !== 1'b1 || q0 !== m_q[0])
        $display("FAIL level_cycle n=%0d: got q=%b any=%b expected q=%b any=1", n, q0, any0, m_q[0]);
      else n_pass++;
      n_total++;
      if (q1 !== m_q[1] || any1 !== m_any[1])
        $display("FAIL level_edgedut n=%0d: got q=%b any=%b expected q=%b any=%b", n, q1, any1, m_q[1], m_any[1]);
      else n_pass++;
    end
    n_total++;
    if (q0 !== 4'b1011 || dut_cnt(0, 0) !== 5)
      $display("FAIL level_final: got q=%b cnt=%0d expected q=1011 cnt=5", q0, dut_cnt(0, 0));
    else n_pass++;
  endtask

  task automatic test_edge_toggle();
    bit pat [7] = '{1, 1, 1, 1, 0, 0, 1};
    do_reset();
    mode = 2'b00; enable = 4'b0010;
    for (int n = 0; n < 7; n++) begin
      d = {2'b00, pat[n], 1'b0};
      step();
      n_total++;
      if (any1 !== m_any[1] || q1 !== m_q[1])
        $display("FAIL edge_cycle n=%0d: got q=%b any=%b expected q=%b any=%b", n, q1, any1, m_q[1], m_any[1]);
      else n_pass++;
    end
    n_total++;
    if (dut_cnt(1, 1) !== 2 || q1 !== 4'b1010)
      $display("FAIL edge_final: got cnt=%0d q=%b expected cnt=2 q=1010", dut_cnt(1, 1), q1);
    else n_pass++;
    n_total++;
    if (dut_cnt(0, 1) !== m_cnt[0][1] || q0 !== m_q[0])
      $display("FAIL edge_leveldut: got cnt=%0d q=%b expected cnt=%0d q=%b", dut_cnt(0, 1), q0, m_cnt[0][1], m_q[0]);
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    mode = 2'b00; enable = 4'b0100; d = 4'b0100;
    for (int n = 1; n <= 9; n++) begin
      step();
      n_total++;
      if (dut_cnt(0, 2) !== ((n < 7) ? n : 7) || sat0[2] !== (n >= 8) || any0 !== 1'b1)
        $display("FAIL sat_cycle n=%0d: got cnt=%0d sat=%b any=%b expected cnt=%0d sat=%0d any=1",
                 n, dut_cnt(0, 2), sat0[2], any0, (n < 7) ? n : 7, n >= 8);
      else n_pass++;
    end
    n_total++;
    if (q0 !== 4'b1110) $display("FAIL sat_q: got %b expected 1110", q0);
    else n_pass++;
  endtask

  task automatic test_count_clr();
    count_clr = 1'b1; mode = 2'b00; enable = 4'b0001; d = 4'b0001;
    step();
    count_clr = 1'b0;
    n_total++;
    if (tc0 !== 12'd0 || sat0 !== 4'b0000 || q0 !== 4'b1111 || any0 !== 1'b1)
      $display("FAIL clr_vs_toggle: got tc=%h sat=%b q=%b any=%b expected 000/0000/1111/1", tc0, sat0, q0, any0);
    else n_pass++;
    n_total++;
    if (tc1 !== 32'd0 || sat1 !== 4'b0000 || q1 !== m_q[1] || any1 !== m_any[1])
      $display("FAIL clr_edgedut: got tc=%h sat=%b q=%b any=%b expected 0/0000/%b/%b", tc1, sat1, q1, any1, m_q[1], m_any[1]);
    else n_pass++;
  endtask

  task automatic test_modes();
    do_reset();
    mode = 2'b00; enable = 4'b0001; d = 4'b0001;
    step(); step();
    mode = 2'b01; d = 4'b1111; enable = 4'b0011;
    step();
    n_total++;
    if (q0[1:0] !== 2'b11 || any0 !== 1'b0 || q1 !== m_q[1] || any1 !== 1'b0)
      $display("FAIL mode_set: got q0=%b any0=%b q1=%b any1=%b expected q0[1:0]=11 any=0", q0, any0, q1, any1);
    else n_pass++;
    mode = 2'b10; d = 4'b0001;
    step();
    n_total++;
    if (q0 !== 4'b1010 || any0 !== 1'b0 || q1 !== m_q[1] || any1 !== 1'b0)
      $display("FAIL mode_clear: got q0=%b any0=%b q1=%b any1=%b expected q0=1010 any=0", q0, any0, q1, any1);
    else n_pass++;
    mode = 2'b11; load_val = 4'b1100; enable = 4'b1111; d = 4'($urandom);
    step();
    n_total++;
    if (q0 !== 4'b1100 || q1 !== 4'b1100 || any0 !== 1'b0 || any1 !== 1'b0)
      $display("FAIL mode_load: got q0=%b q1=%b any=%b%b expected 1100/1100 any=0", q0, q1, any0, any1);
    else n_pass++;
    n_total++;
    if (dut_cnt(0, 0) !== 2 || dut_cnt(1, 0) !== 1 || dut_cnt(0, 1) !== 0)
      $display("FAIL mode_counts: got c00=%0d c10=%0d c01=%0d expected 2/1/0", dut_cnt(0, 0), dut_cnt(1, 0), dut_cnt(0, 1));
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    mode = 2'b00; enable = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      d = 4'($urandom);
      step();
    end
    reset = 1'b1; d = 4'($urandom); mode = 2'($urandom); enable = 4'($urandom); count_clr = 1'($urandom);
    step();
    reset = 1'b0; count_clr = 1'b0;
    n_total++;
    if (q0 !== INIT_V || q1 !== INIT_V || tc0 !== 12'd0 || tc1 !== 32'd0 ||
        sat0 !== 4'b0 || sat1 !== 4'b0 || any0 !== 1'b0 || any1 !== 1'b0)
      $display("FAIL mid_reset: got q=%b/%b tc=%h/%h sat=%b/%b any=%b%b expected 1010 zeros",
               q0, q1, tc0, tc1, sat0, sat1, any0, any1);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      count_clr = ($urandom_range(0, 24) == 0);
      mode      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      enable    = 4'($urandom);
      d         = 4'($urandom);
      load_val  = 4'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (dut_q(k) !== m_q[k] || dut_sat(k) !== m_sat[k] || dut_any(k) !== m_any[k])
          $display("FAIL rand_state dut%0d n=%0d: got q=%b sat=%b any=%b expected q=%b sat=%b any=%b",
                   k, n, dut_q(k), dut_sat(k), dut_any(k), m_q[k], m_sat[k], m_any[k]);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
          n_total++;
          if (dut_cnt(k, i) !== m_cnt[k][i])
            $display("FAIL rand_cnt dut%0d ch%0d n=%0d: got %0d expected %0d", k, i, n, dut_cnt(k, i), m_cnt[k][i]);
          else n_pass++;
        end
      end
    end
    reset = 1'b0; count_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = '0; d = '0; mode = '0; load_val = '0; count_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_level_toggle();
    test_edge_toggle();
    test_saturate();
    test_count_clr();
    test_modes();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
